// File: rtl/word_assembler_pkg.sv
// Shared types and defaults for the byte-to-word collector.
// The debug-unit UART blocks use the same byte/word sizing constants.
package word_assembler_pkg;

    localparam int WA_DATA_SIZE   = 8;
    localparam int WA_LANES       = 4;
    localparam int WA_SIZE_SELECT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10
    } wa_state_e;

endpackage : word_assembler_pkg

// File: rtl/word_assembler_lane_decoder.sv
// Lane index to one-hot write strobe decoder; the inverse of the 4:1 word select.
module lane_decoder #(
    parameter int LANES       = 4,
    parameter int SIZE_SELECT = 2
) (
    input  logic                   en_i,
    input  logic [SIZE_SELECT-1:0] idx_i,
    output logic [LANES-1:0]       strobe_o
);

    // One-hot strobe for the addressed lane, all-zero when disabled
    always_comb begin
        strobe_o = {LANES{1'b0}};
        if (en_i) begin
            strobe_o[idx_i] = 1'b1;
        end else begin
            strobe_o = {LANES{1'b0}};
        end
    end

endmodule : lane_decoder

// File: rtl/word_assembler.sv
// Collects LANES consecutive bytes into one word and offers it downstream
// with a valid/ready handshake; bytes arriving while a word is held set a sticky overrun.
module word_assembler
    import word_assembler_pkg::*;
#(
    parameter int DATA_SIZE   = WA_DATA_SIZE,
    parameter int LANES       = WA_LANES,
    parameter int SIZE_SELECT = WA_SIZE_SELECT,
    parameter int BIG_ENDIAN  = 0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_byte_valid,
    input  logic [DATA_SIZE-1:0]         i_byte,
    input  logic                         i_flush,
    input  logic                         i_ready,
    output logic [DATA_SIZE*LANES-1:0]   o_word,
    output logic                         o_word_valid,
    output logic [SIZE_SELECT-1:0]       o_lane_sel,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam int  WORD_W = DATA_SIZE * LANES;
    localparam logic [SIZE_SELECT-1:0] LAST_LANE = SIZE_SELECT'(LANES - 1);

    wa_state_e              state_q, state_d;
    logic [SIZE_SELECT-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic                   overrun_q, overrun_d;
    logic                   wr_en_s;
    logic [SIZE_SELECT-1:0] lane_idx_s;
    logic [LANES-1:0]       lane_wr_s;

    // LANES is a power of two, so LANES-1-cnt is simply the bitwise complement
    assign lane_idx_s = (BIG_ENDIAN != 0) ? ~cnt_q : cnt_q;

    lane_decoder #(
        .LANES       (LANES),
        .SIZE_SELECT (SIZE_SELECT)
    ) u_lane_decoder (
        .en_i     (wr_en_s),
        .idx_i    (lane_idx_s),
        .strobe_o (lane_wr_s)
    );

    // Next-state, lane counter, overrun and write-enable decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        wr_en_s   = 1'b0;
        if (i_flush) begin
            state_d   = ST_IDLE;
            cnt_d     = {SIZE_SELECT{1'b0}};
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (i_byte_valid) begin
                        wr_en_s = 1'b1;
                        if (cnt_q == LAST_LANE) begin
                            cnt_d   = {SIZE_SELECT{1'b0}};
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d   = cnt_q + SIZE_SELECT'(1);
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_HOLD: begin
                    // cnt is 0 here, so an accepted byte lands in the first lane
                    if (i_ready) begin
                        if (i_byte_valid) begin
                            wr_en_s = 1'b1;
                            cnt_d   = SIZE_SELECT'(1);
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (i_byte_valid) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {SIZE_SELECT{1'b0}};
                end
            endcase
        end
    end

    // Word contents: flush clears, strobed lanes load, others retain
    always_comb begin
        word_d = word_q;
        if (i_flush) begin
            word_d = {WORD_W{1'b0}};
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_wr_s[l]) begin
                    word_d[l*DATA_SIZE +: DATA_SIZE] = i_byte;
                end else begin
                    word_d[l*DATA_SIZE +: DATA_SIZE] = word_q[l*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {SIZE_SELECT{1'b0}};
            word_q    <= {WORD_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = (state_q == ST_HOLD);
    assign o_lane_sel   = cnt_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_overrun    = overrun_q;

endmodule : word_assembler

// File: tb/tb_word_assembler.sv
// Directed bench: little- and big-endian instances share stimulus; a vector table
// covers the main flow, hand-written sequences cover async reset and streaming.
module tb_word_assembler;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        flush;
    logic        ready;

    logic [31:0] le_word, be_word;
    logic        le_valid, be_valid;
    logic [1:0]  le_sel, be_sel;
    logic        le_busy, be_busy;
    logic        le_ovr, be_ovr;

    int n_cmp = 0;
    int n_err = 0;

    word_assembler #(.DATA_SIZE(8), .LANES(4), .SIZE_SELECT(2), .BIG_ENDIAN(0)) dut_le (
        .i_clk(clk), .i_reset(rst), .i_byte_valid(byte_valid), .i_byte(byte_in),
        .i_flush(flush), .i_ready(ready), .o_word(le_word), .o_word_valid(le_valid),
        .o_lane_sel(le_sel), .o_busy(le_busy), .o_overrun(le_ovr)
    );

    word_assembler #(.DATA_SIZE(8), .LANES(4), .SIZE_SELECT(2), .BIG_ENDIAN(1)) dut_be (
        .i_clk(clk), .i_reset(rst), .i_byte_valid(byte_valid), .i_byte(byte_in),
        .i_flush(flush), .i_ready(ready), .o_word(be_word), .o_word_valid(be_valid),
        .o_lane_sel(be_sel), .o_busy(be_busy), .o_overrun(be_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic [7:0]  b;
        logic        fl;
        logic        rd;
        logic [31:0] le_w;
        logic [31:0] be_w;
        logic        v;
        logic [1:0]  sel;
        logic        busy;
        logic        ovr;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic fl, input logic rd);
        byte_valid = bv;
        byte_in    = b;
        flush      = fl;
        ready      = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_le(input string name, input logic [31:0] w, input logic v,
                          input logic [1:0] sel, input logic busy, input logic ovr);
        chk({name, ".word"},  le_word,        w);
        chk({name, ".valid"}, 32'(le_valid),  32'(v));
        chk({name, ".sel"},   32'(le_sel),    32'(sel));
        chk({name, ".busy"},  32'(le_busy),   32'(busy));
        chk({name, ".ovr"},   32'(le_ovr),    32'(ovr));
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 32'h0000_0011, 32'h1100_0000, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 32'h0000_2211, 32'h1122_0000, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 32'h0033_2211, 32'h1122_3300, 1'b0, 2'd3, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 32'h4433_2211, 32'h1122_3344, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h4433_2211, 32'h1122_3344, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h4433_2211, 32'h1122_3344, 1'b1, 2'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 32'h4433_2255, 32'h5522_3344, 1'b0, 2'd1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h4433_2255, 32'h5522_3344, 1'b0, 2'd1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h66, 1'b0, 1'b0, 32'h4433_6655, 32'h5566_3344, 1'b0, 2'd2, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h77, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0000_0001, 32'h0100_0000, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0000_0201, 32'h0102_0000, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0003_0201, 32'h0102_0300, 1'b0, 2'd3, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h04, 1'b0, 1'b0, 32'h0403_0201, 32'h0102_0304, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h0403_0201, 32'h0102_0304, 1'b0, 2'd0, 1'b0, 1'b0};

        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; flush = 1'b0; ready = 1'b0;
        #3;
        chk_le("reset", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.be_word", be_word, 32'h0);
        #9 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].bv, vecs[i].b, vecs[i].fl, vecs[i].rd);
            chk_le($sformatf("v%0d", i), vecs[i].le_w, vecs[i].v, vecs[i].sel, vecs[i].busy, vecs[i].ovr);
            chk($sformatf("v%0d.be_word", i), be_word, vecs[i].be_w);
            chk($sformatf("v%0d.be_valid", i), 32'(be_valid), 32'(vecs[i].v));
        end

        // Asynchronous reset between edges after the third byte
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_le("async_rst", 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b0, 1'b0);
        step(1'b1, 8'hD3, 1'b0, 1'b0);
        step(1'b1, 8'hD4, 1'b0, 1'b0);
        chk_le("post_rst", 32'hD4D3_D2D1, 1'b1, 2'd0, 1'b1, 1'b0);
        chk("post_rst.be_word", be_word, 32'hD1D2_D3D4);

        // Drain the held word, then stream 8 bytes with ready held high
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_le("drain", 32'hD4D3_D2D1, 1'b0, 2'd0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) step(1'b1, 8'(8'hE0 + k), 1'b0, 1'b1);
            else       step(1'b0, 8'h00, 1'b0, 1'b1);
            if (le_valid) pulses++;
            if (k == 3) chk_le("stream.w0", 32'hE3E2_E1E0, 1'b1, 2'd0, 1'b1, 1'b0);
            if (k == 4) chk_le("stream.hs", 32'hE3E2_E1E4, 1'b0, 2'd1, 1'b1, 1'b0);
            if (k == 7) chk_le("stream.w1", 32'hE7E6_E5E4, 1'b1, 2'd0, 1'b1, 1'b0);
            if (k == 8) chk_le("stream.end", 32'hE7E6_E5E4, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        chk("stream.pulses", 32'(pulses), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_word_assembler
